i2c_arbiter: RTL and testbench
==============================

Name: i2c_arbiter

Overview:
- Shares one i2c master instance between NREQ independent requesters, e.g. the GPIO-expander poller, a video-DAC configurator and an RTC reader.
- Grants round-robin, latches the winner's transaction fields and sequences the master's START/END handshake.
- Returns completion, NACK status and read data to the winner.
- Adds a watchdog so a stalled bus cannot hang all requesters silently.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TIMEOUT, 65535, max clk cycles per transaction before abort.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester transaction request, level
- req_rd  in  NREQ  1=read, 0=write
- req_addr  in  7*NREQ  7-bit device address, requester k at [7k+6:7k]
- req_wlen  in  NREQ  0=one write byte, 1=two write bytes
- req_wdata1  in  8*NREQ  first write byte (register index)
- req_wdata2  in  8*NREQ  second write byte
- done  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  NACK/abort status, valid while any done bit is high
- rdata  out  8  read data, valid while any done bit is high
- busy  out  1  transaction in progress
- timeout_flag  out  1  sticky, set on any watchdog abort
- i2c_start  out  1  to master START
- i2c_read  out  1  to master READ
- i2c_addr  out  7  to master I2C_ADDR
- i2c_wlen  out  1  to master I2C_WLEN
- i2c_wdata1  out  8  to master I2C_WDATA1
- i2c_wdata2  out  8  to master I2C_WDATA2
- i2c_rdata  in  8  from master I2C_RDATA
- i2c_end  in  1  from master END: high when idle, low while running
- i2c_ack  in  1  from master ACK: high = NACK/error

Behaviour:
- Reset:
  - All outputs 0; state IDLE; priority pointer 0; timeout_flag cleared.
  - Reset is honoured mid-transaction. i2c_start drops immediately.
  - The master may finish its current frame; the arbiter ignores it.
- IDLE:
  - Winner = first k with req[k]=1, searching from pointer upward with wrap.
  - On a winner: latch its rd/addr/wlen/wdata1/wdata2 into the i2c_* registers, store grant index, clear watchdog, go LAUNCH.
  - No req: stay IDLE.
- LAUNCH:
  - i2c_start=1 (first asserted the cycle after the grant).
  - When i2c_end=0: go WAIT.
- WAIT:
  - i2c_start=0.
  - When i2c_end=1: latch rdata<=i2c_rdata and err<=i2c_ack, go DONE.
- DONE (one cycle):
  - done[grant]=1.
  - pointer <= grant+1, wrapping at NREQ.
  - Go IDLE.
  - Latency: one single-cycle done pulse per transaction; the earliest re-grant is the cycle after DONE.
- busy=1 in LAUNCH, WAIT, DONE and DRAIN.
- i2c_* fields are stable from grant through DONE. Requester inputs are not sampled after the grant.
- Requester rule: hold req and fields until done.
  - req dropped before grant: not served.
  - req dropped after grant: transaction still completes and done still pulses.
  - req still high after done: treated as a new request, but lower priority than the others under round-robin.
- Watchdog:
  - Counts every cycle in LAUNCH and WAIT.
  - When count reaches TIMEOUT-1: go DRAIN, set timeout_flag, set err=1, rdata=0.
- DRAIN:
  - i2c_start=0; wait for i2c_end=1, unbounded.
  - Then pulse done[grant] with err=1 and go IDLE.
  - The pointer advances as in DONE.
- Outside a done pulse, err and rdata hold their last value.
- Simultaneous requests: exactly one grant per arbitration. Every pending requester is served within NREQ transactions (no starvation).

Test Plan:
- req[0] write, addr 0x20, wlen=1, wdata 0x05/0x24; model master END low 10 cycles, ACK=0 -> i2c_addr=0x20, i2c_wdata1=0x05, i2c_wdata2=0x24 stable throughout; exactly one done[0] pulse, err=0; busy returns to 0.
- req[1] read, addr 0x20, wdata1 0x09; master returns 0xA5 -> done[1] pulse with rdata=0xA5, err=0; i2c_read=1 during the transaction.
- req[2:0]=111 held continuously from reset -> grants 0,1,2,0,1,2 in order. Then req[2] only -> granted at the next IDLE.
- Master ACK=1 on completion -> done pulse with err=1; timeout_flag stays 0.
- TIMEOUT=100, master holds END low for 300 cycles -> i2c_start low from cycle 100; timeout_flag=1; done with err=1 and rdata=0 only after END rises. The next requester is served afterwards.
- reset_n pulsed low during WAIT -> all outputs 0 asynchronously. After release, the arbiter re-arbitrates from pointer 0 and no stale done is produced.

Source files
------------

// File: rtl/i2c_arbiter_if.sv
// rtl/i2c_arbiter_if.sv - command/response bundle between the arbiter and the shared i2c master
interface i2c_arbiter_if;
  logic       i2c_start;
  logic       i2c_read;
  logic [6:0] i2c_addr;
  logic       i2c_wlen;
  logic [7:0] i2c_wdata1;
  logic [7:0] i2c_wdata2;
  logic [7:0] i2c_rdata;
  logic       i2c_end;
  logic       i2c_ack;

  modport master (
    output i2c_start, i2c_read, i2c_addr, i2c_wlen, i2c_wdata1, i2c_wdata2,
    input  i2c_rdata, i2c_end, i2c_ack
  );

  modport slave (
    input  i2c_start, i2c_read, i2c_addr, i2c_wlen, i2c_wdata1, i2c_wdata2,
    output i2c_rdata, i2c_end, i2c_ack
  );
endinterface

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin sharing of one i2c master between NREQ requesters, with watchdog
module i2c_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rd,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_wlen,
  input  logic [8*NREQ-1:0] req_wdata1,
  input  logic [8*NREQ-1:0] req_wdata2,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              timeout_flag,
  i2c_arbiter_if.master     bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(NREQ - 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_grant;
  logic [WW-1:0]   r_wd;
  logic [NREQ-1:0] r_done;
  logic            r_err;
  logic [7:0]      r_rdata;
  logic            r_busy;
  logic            r_timeout;
  logic            r_start;
  logic            r_read;
  logic [6:0]      r_addr;
  logic            r_wlen;
  logic [7:0]      r_wdata1;
  logic [7:0]      r_wdata2;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [NREQ-1:0] w_grant_oh;

  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[rot_idx(r_ptr, i)]) begin
        w_found = 1'b1;
        w_win   = rot_idx(r_ptr, i);
      end
    end
  end

  assign w_grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_wd      <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_start   <= 1'b0;
      r_read    <= 1'b0;
      r_addr    <= '0;
      r_wlen    <= 1'b0;
      r_wdata1  <= '0;
      r_wdata2  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant  <= w_win;
            r_read   <= req_rd[w_win];
            r_addr   <= req_addr[7*int'(w_win) +: 7];
            r_wlen   <= req_wlen[w_win];
            r_wdata1 <= req_wdata1[8*int'(w_win) +: 8];
            r_wdata2 <= req_wdata2[8*int'(w_win) +: 8];
            r_wd     <= '0;
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH, S_WAIT: begin
          // Watchdog wins over a same-cycle END edge so an abort is never half-reported.
          if (r_wd == WD_LAST) begin
            r_start   <= 1'b0;
            r_timeout <= 1'b1;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_state   <= S_DRAIN;
          end else begin
            r_wd <= r_wd + 1'b1;
            if (r_state == S_LAUNCH) begin
              if (!bus.i2c_end) begin
                r_start <= 1'b0;
                r_state <= S_WAIT;
              end
            end else if (bus.i2c_end) begin
              r_rdata <= bus.i2c_rdata;
              r_err   <= bus.i2c_ack;
              r_done  <= w_grant_oh;
              r_state <= S_DONE;
            end
          end
        end
        S_DRAIN: begin
          if (bus.i2c_end) begin
            r_done  <= w_grant_oh;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ptr   <= (r_grant == P_LAST) ? '0 : r_grant + 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done           = r_done;
  assign err            = r_err;
  assign rdata          = r_rdata;
  assign busy           = r_busy;
  assign timeout_flag   = r_timeout;
  assign bus.i2c_start  = r_start;
  assign bus.i2c_read   = r_read;
  assign bus.i2c_addr   = r_addr;
  assign bus.i2c_wlen   = r_wlen;
  assign bus.i2c_wdata1 = r_wdata1;
  assign bus.i2c_wdata2 = r_wdata2;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed checks of i2c_arbiter against a behavioural i2c master
module tb_i2c_arbiter;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req, req_rd, req_wlen;
  logic [20:0] req_addr;
  logic [23:0] req_wdata1, req_wdata2;
  logic [2:0]  done;
  logic        err;
  logic [7:0]  rdata;
  logic        busy, timeout_flag;

  i2c_arbiter_if bus();

  i2c_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req(req), .req_rd(req_rd), .req_addr(req_addr), .req_wlen(req_wlen),
    .req_wdata1(req_wdata1), .req_wdata2(req_wdata2),
    .done(done), .err(err), .rdata(rdata), .busy(busy), .timeout_flag(timeout_flag),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master model: END drops when START is seen, rises m_len cycles later with result.
  int         m_len   = 10;
  int         m_cnt   = 0;
  logic [7:0] m_rdata = 8'h00;
  logic       m_ack   = 1'b0;
  initial begin
    bus.i2c_end   = 1'b1;
    bus.i2c_ack   = 1'b0;
    bus.i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.i2c_rdata = m_rdata;
          bus.i2c_ack   = m_ack;
          bus.i2c_end   = 1'b1;
        end
      end else if (bus.i2c_start) begin
        bus.i2c_end = 1'b0;
        m_cnt       = m_len;
      end
    end
  end

  int n_done = 0;
  always @(posedge clk) if (|done) n_done++;

  logic       watch    = 1'b0;
  logic       unstable = 1'b0;
  logic [6:0] w_addr;
  logic [7:0] w_d1, w_d2;
  always @(negedge clk)
    if (watch && (bus.i2c_addr !== w_addr || bus.i2c_wdata1 !== w_d1 || bus.i2c_wdata2 !== w_d2))
      unstable = 1'b1;

  task automatic load(input int k, input logic rd, input logic [6:0] a, input logic wl,
                      input logic [7:0] d1, input logic [7:0] d2);
    req_rd[k]           = rd;
    req_addr[7*k +: 7]  = a;
    req_wlen[k]         = wl;
    req_wdata1[8*k +: 8] = d1;
    req_wdata2[8*k +: 8] = d2;
  endtask

  task automatic wait_start(input string tag);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.i2c_start) return;
    end
    check({tag, "_start_seen"}, 0, 1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int idx,
                           output logic e, output logic [7:0] rd, output logic [2:0] dv);
    idx = -1; e = 1'b0; rd = 8'h00; dv = 3'b000;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (|done) begin
        for (int k = 0; k < NREQ; k++) if (done[k]) idx = k;
        e = err; rd = rdata; dv = done;
        return;
      end
    end
    check({tag, "_done_seen"}, 0, 1);
  endtask

  int         idx, base;
  logic       e;
  logic [7:0] rd;
  logic [2:0] dv;

  initial begin
    reset_n = 1'b0; req = '0; req_rd = '0; req_wlen = '0;
    req_addr = '0; req_wdata1 = '0; req_wdata2 = '0;
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_tflag", timeout_flag, 0);
    check("rst_start", bus.i2c_start, 0);
    check("rst_addr", bus.i2c_addr, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Two-byte write from requester 0
    load(0, 1'b0, 7'h20, 1'b1, 8'h05, 8'h24);
    m_len = 10; m_ack = 1'b0; base = n_done;
    req = 3'b001;
    wait_start("t1");
    check("t1_addr", bus.i2c_addr, 7'h20);
    check("t1_wdata1", bus.i2c_wdata1, 8'h05);
    check("t1_wdata2", bus.i2c_wdata2, 8'h24);
    check("t1_wlen", bus.i2c_wlen, 1);
    check("t1_read", bus.i2c_read, 0);
    check("t1_busy", busy, 1);
    w_addr = 7'h20; w_d1 = 8'h05; w_d2 = 8'h24; watch = 1'b1;
    wait_done("t1", 40, idx, e, rd, dv);
    watch = 1'b0;
    req = 3'b000;
    check("t1_done_vec", dv, 3'b001);
    check("t1_err", e, 0);
    repeat (3) @(negedge clk);
    check("t1_stable", unstable, 0);
    check("t1_done_count", n_done - base, 1);
    check("t1_busy_after", busy, 0);

    // Read from requester 1
    load(1, 1'b1, 7'h20, 1'b0, 8'h09, 8'h00);
    m_rdata = 8'hA5;
    req = 3'b010;
    wait_start("t2");
    check("t2_read", bus.i2c_read, 1);
    check("t2_addr", bus.i2c_addr, 7'h20);
    check("t2_wdata1", bus.i2c_wdata1, 8'h09);
    wait_done("t2", 40, idx, e, rd, dv);
    req = 3'b000;
    check("t2_idx", idx, 1);
    check("t2_rdata", rd, 8'hA5);
    check("t2_err", e, 0);
    repeat (2) @(negedge clk);

    // All three requesting from reset: strict rotation
    reset_n = 1'b0;
    for (int k = 0; k < NREQ; k++) load(k, 1'b0, 7'(7'h10 + k), 1'b0, 8'(8'h30 + k), 8'h00);
    m_rdata = 8'h00;
    req = 3'b111;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_done($sformatf("t3_%0d", i), 40, idx, e, rd, dv);
      check($sformatf("t3_grant%0d", i), idx, i % 3);
      check($sformatf("t3_addr%0d", i), bus.i2c_addr, 7'(7'h10 + (i % 3)));
    end
    req = 3'b100;
    wait_done("t3_solo", 40, idx, e, rd, dv);
    req = 3'b000;
    check("t3_solo_grant", idx, 2);
    repeat (2) @(negedge clk);

    // NACK from the master
    load(0, 1'b0, 7'h20, 1'b0, 8'h01, 8'h00);
    m_ack = 1'b1;
    req = 3'b001;
    wait_done("t4", 40, idx, e, rd, dv);
    req = 3'b000;
    check("t4_idx", idx, 0);
    check("t4_err", e, 1);
    check("t4_tflag", timeout_flag, 0);
    m_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Watchdog abort on a stuck frame
    load(1, 1'b0, 7'h22, 1'b0, 8'h02, 8'h00);
    m_len = 300; m_rdata = 8'h5A;
    req = 3'b010;
    wait_start("t5");
    repeat (99) @(negedge clk);
    check("t5_tflag_before", timeout_flag, 0);
    check("t5_busy", busy, 1);
    @(negedge clk);
    check("t5_tflag", timeout_flag, 1);
    check("t5_err_now", err, 1);
    check("t5_rdata_now", rdata, 0);
    check("t5_start_low", bus.i2c_start, 0);
    check("t5_no_early_done", done, 0);
    wait_done("t5", 400, idx, e, rd, dv);
    check("t5_idx", idx, 1);
    check("t5_err", e, 1);
    check("t5_rdata", rd, 0);
    check("t5_end_high", bus.i2c_end, 1);
    load(0, 1'b0, 7'h23, 1'b0, 8'h03, 8'h00);
    m_len = 10;
    req = 3'b001;
    wait_done("t5_next", 40, idx, e, rd, dv);
    req = 3'b000;
    check("t5_next_idx", idx, 0);
    check("t5_next_err", e, 0);
    check("t5_tflag_sticky", timeout_flag, 1);
    repeat (2) @(negedge clk);

    // Reset in the middle of WAIT
    load(1, 1'b0, 7'h24, 1'b0, 8'h04, 8'h00);
    m_len = 20;
    req = 3'b010;
    wait_start("t6");
    repeat (5) @(negedge clk);
    check("t6_busy", busy, 1);
    base = n_done;
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_start", bus.i2c_start, 0);
    check("t6_rst_tflag", timeout_flag, 0);
    check("t6_rst_rdata", rdata, 0);
    check("t6_rst_addr", bus.i2c_addr, 0);
    check("t6_rst_done", done, 0);
    load(0, 1'b0, 7'h25, 1'b0, 8'h05, 8'h00);
    req = 3'b011;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.i2c_end) break;
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_done("t6", 40, idx, e, rd, dv);
    req = 3'b000;
    check("t6_regrant_idx", idx, 0);
    check("t6_regrant_addr", bus.i2c_addr, 7'h25);
    repeat (3) @(negedge clk);
    check("t6_done_count", n_done - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
